// File: rtl/sensor_status_encoder.sv
// Conditions the IR and overcurrent inputs and produces the {L,C,R,O} status code for the display,
// plus the motor enable and a saturating count of overcurrent fault entries.
module sensor_status_encoder #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int OC_FILTER_CYCLES  = 100,
    parameter int COOLDOWN_CYCLES   = 50000000,
    parameter int SENSOR_ACTIVE_LOW = 1,
    parameter int CNT_W             = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_left,
    input  logic       ir_center,
    input  logic       ir_right,
    input  logic       oc_raw,
    input  logic       oc_clear,
    output logic [3:0] number,
    output logic       oc_fault,
    output logic       motor_en,
    output logic [7:0] fault_count
);

    localparam logic             IR_IDLE  = (SENSOR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OCF_LAST = CNT_W'(OC_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {NORMAL, FILTER, FAULT, COOLDOWN} oc_state_t;

    logic [2:0]       ir_m, ir_s, det, deb;
    logic             oc_m, oc_s, clr_m, clr_s, clr_d, clr_p;
    logic [CNT_W-1:0] db_cnt [3];
    oc_state_t        state, state_n;
    logic [CNT_W-1:0] k, k_n;
    logic             fault_entry, in_fault;

    // IR bit order throughout is {left, center, right}
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_m  <= {3{IR_IDLE}};
            ir_s  <= {3{IR_IDLE}};
            oc_m  <= 1'b0;
            oc_s  <= 1'b0;
            clr_m <= 1'b0;
            clr_s <= 1'b0;
            clr_d <= 1'b0;
        end else begin
            ir_m  <= {ir_left, ir_center, ir_right};
            ir_s  <= ir_m;
            oc_m  <= oc_raw;
            oc_s  <= oc_m;
            clr_m <= oc_clear;
            clr_s <= clr_m;
            clr_d <= clr_s;
        end
    end

    assign det   = IR_IDLE ? ~ir_s : ir_s;
    assign clr_p = clr_s & ~clr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (det[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= det[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_n     = state;
        k_n         = k;
        fault_entry = 1'b0;
        unique case (state)
            NORMAL: begin
                if (oc_s) begin
                    state_n = FILTER;
                    k_n     = '0;
                end
            end
            FILTER: begin
                if (!oc_s) begin
                    state_n = NORMAL;
                end else if (k == OCF_LAST) begin
                    state_n     = FAULT;
                    k_n         = '0;
                    fault_entry = 1'b1;
                end else begin
                    k_n = k + CNT_W'(1);
                end
            end
            FAULT: begin
                // a clear only counts once the overcurrent condition is gone
                if (clr_p && !oc_s) begin
                    state_n = COOLDOWN;
                    k_n     = '0;
                end
            end
            COOLDOWN: begin
                if (oc_s) begin
                    state_n = FAULT;
                end else if (k == CD_LAST) begin
                    state_n = NORMAL;
                    k_n     = '0;
                end else begin
                    k_n = k + CNT_W'(1);
                end
            end
            default: state_n = NORMAL;
        endcase
    end

    assign in_fault = (state == FAULT) || (state == COOLDOWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NORMAL;
            k           <= '0;
            fault_count <= '0;
            number      <= '0;
            oc_fault    <= 1'b0;
            motor_en    <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            if (fault_entry && fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
            number   <= in_fault ? 4'b0001 : {deb, 1'b0};
            oc_fault <= in_fault;
            motor_en <= !in_fault;
        end
    end

endmodule

// File: tb/tb_sensor_status_encoder.sv
// Randomised and directed stimulus for sensor_status_encoder; a reference model queues the expected
// outputs for each clock edge and an independent monitor pops and compares them.
module tb_sensor_status_encoder;

    localparam int DB  = 8;
    localparam int OCF = 4;
    localparam int CD  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ir_left = 1'b1, ir_center = 1'b1, ir_right = 1'b1;
    logic       oc_raw = 1'b0, oc_clear = 1'b0;
    logic [3:0] number;
    logic       oc_fault, motor_en;
    logic [7:0] fault_count;

    sensor_status_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .OC_FILTER_CYCLES(OCF),
        .COOLDOWN_CYCLES(CD),
        .SENSOR_ACTIVE_LOW(1),
        .CNT_W(26)
    ) dut (
        .clk(clk), .rst(rst),
        .ir_left(ir_left), .ir_center(ir_center), .ir_right(ir_right),
        .oc_raw(oc_raw), .oc_clear(oc_clear),
        .number(number), .oc_fault(oc_fault), .motor_en(motor_en),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        logic       ocf;
        logic       men;
        logic [7:0] fc;
        int         cyc;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Model: raw inputs seen through a 2-edge delay line, then rule-level debounce and fault tracking.
    // Packed raw sample layout: {left, center, right, oc, clear}.
    logic [4:0] hist [3];
    logic [2:0] m_d;
    int         m_run [3];
    bit         m_fault, m_cool;
    int         m_hi, m_cr, m_fc;

    task automatic model_step(input bit r, input logic [4:0] raw);
        exp_t       e;
        logic [4:0] s;
        logic [2:0] det;
        bit         o, cp;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                hist[i]  = 5'b11100;
                m_run[i] = 0;
            end
            m_d = '0; m_fault = 0; m_cool = 0; m_hi = 0; m_cr = 0; m_fc = 0;
            e.num = 4'b0000; e.ocf = 1'b0; e.men = 1'b0; e.fc = 8'd0;
        end else begin
            e.num = m_fault ? 4'b0001 : {m_d, 1'b0};
            e.ocf = m_fault;
            e.men = !m_fault;
            s   = hist[1];
            det = ~s[4:2];
            o   = s[1];
            cp  = s[0] && !hist[0][0];
            for (int i = 0; i < 3; i++) begin
                if (det[i] == m_d[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_d[i]   = det[i];
                        m_run[i] = 0;
                    end
                end
            end
            if (!m_fault) begin
                if (o) begin
                    m_hi++;
                    if (m_hi == OCF + 1) begin
                        m_fault = 1; m_cool = 0; m_hi = 0;
                        m_fc = (m_fc < 255) ? m_fc + 1 : 255;
                    end
                end else m_hi = 0;
            end else if (!m_cool) begin
                if (cp && !o) begin
                    m_cool = 1; m_cr = 0;
                end
            end else begin
                if (o) m_cool = 0;
                else begin
                    m_cr++;
                    if (m_cr == CD) begin
                        m_fault = 0; m_cool = 0;
                    end
                end
            end
            e.fc = 8'(m_fc);
            hist[0] = hist[1];
            hist[1] = hist[2];
            hist[2] = raw;
        end
        e.cyc = cyc;
        expq.push_back(e);
    endtask

    task automatic drive(input bit r, input logic [2:0] ir, input bit oc, input bit clr);
        @(negedge clk);
        rst       = r;
        ir_left   = ir[2];
        ir_center = ir[1];
        ir_right  = ir[0];
        oc_raw    = oc;
        oc_clear  = clr;
        model_step(r, {ir, oc, clr});
        cyc++;
    endtask

    task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, want);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("number",      e.cyc, {4'b0, number},   {4'b0, e.num});
                chk("oc_fault",    e.cyc, {7'b0, oc_fault}, {7'b0, e.ocf});
                chk("motor_en",    e.cyc, {7'b0, motor_en}, {7'b0, e.men});
                chk("fault_count", e.cyc, fault_count,      e.fc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached at cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [2:0] irv;
        int         hold;
        bit         ocv, clv;

        repeat (3) drive(1, 3'b111, 0, 0);
        repeat (4) drive(0, 3'b111, 0, 0);

        // left detection held, then a short right glitch that must not register
        repeat (14) drive(0, 3'b011, 0, 0);
        repeat (5)  drive(0, 3'b010, 0, 0);
        repeat (12) drive(0, 3'b011, 0, 0);

        // short overcurrent burst, then a sustained one with center also active
        repeat (3)  drive(0, 3'b011, 1, 0);
        repeat (6)  drive(0, 3'b011, 0, 0);
        repeat (12) drive(0, 3'b001, 0, 0);
        repeat (12) drive(0, 3'b001, 1, 0);

        // clear while overcurrent persists is ignored; then a real clear and full cooldown
        repeat (2)  drive(0, 3'b001, 1, 1);
        repeat (4)  drive(0, 3'b001, 1, 0);
        repeat (4)  drive(0, 3'b001, 0, 0);
        repeat (2)  drive(0, 3'b001, 0, 1);
        repeat (25) drive(0, 3'b001, 0, 0);

        // re-trip during cooldown, then clear and overcurrent together
        repeat (8)  drive(0, 3'b111, 1, 0);
        repeat (3)  drive(0, 3'b111, 0, 0);
        repeat (2)  drive(0, 3'b111, 0, 1);
        repeat (5)  drive(0, 3'b111, 0, 0);
        repeat (4)  drive(0, 3'b111, 1, 0);
        repeat (2)  drive(0, 3'b111, 1, 1);
        repeat (4)  drive(0, 3'b111, 1, 0);
        repeat (3)  drive(0, 3'b111, 0, 0);
        repeat (2)  drive(0, 3'b111, 0, 1);
        repeat (22) drive(0, 3'b111, 0, 0);

        // reset while latched
        repeat (8) drive(0, 3'b110, 1, 0);
        drive(1, 3'b110, 1, 0);
        repeat (4) drive(0, 3'b111, 0, 0);

        for (int i = 0; i < 60; i++) begin
            irv  = 3'($urandom);
            hold = $urandom_range(1, 12);
            ocv  = ($urandom_range(0, 3) == 0);
            clv  = ($urandom_range(0, 2) == 0);
            repeat (hold) drive(0, irv, ocv, clv);
        end

        drive(1, 3'b111, 0, 0);
        for (int i = 0; i < 260; i++) begin
            irv = 3'($urandom);
            repeat (7)  drive(0, irv, 1, 0);
            repeat (2)  drive(0, irv, 0, 0);
            repeat (2)  drive(0, irv, 0, 1);
            repeat (20) drive(0, irv, 0, 0);
        end
        repeat (4) drive(0, 3'b111, 0, 0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (expq.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d expected=0", expq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
